alu: RTL and testbench
======================

ALU -- requirements
Module: ALU

Interface
REQ-001 SHALL have exactly the ports below, in the order listed.
- clk     in   1   sole clock; all state updates on rising edge.
- rst_n   in   1   reset; asynchronous, active-low.
- src1    in   32  operand A, unsigned.
- src2    in   32  operand B, unsigned.
- funct   in   6   operation select.
- result  out  32  registered operation result.
- carry   out  1   registered carry/borrow flag.
- busy    out  1   high while the multiplier is iterating.
REQ-002 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-003 SHALL sample src1, src2 and funct on each rising clk edge when busy=0; result/carry SHALL update on that edge (latency 1 cycle).
REQ-004 funct 6'b001001 ADDU: result = (src1+src2)[31:0]; carry = bit 32 of the 33-bit sum.
REQ-005 funct 6'b001010 SUBU: result = (src1-src2)[31:0] modulo 2^32; carry = 1 iff src1 < src2 (borrow).
REQ-006 funct 6'b001100 AND, 6'b001101 OR, 6'b001110 XOR, 6'b001111 NOR: bitwise on src1, src2; carry = 0.
REQ-007 funct 6'b001011 SLTU: result = {31'b0, src1<src2}; carry = 0.
REQ-008 funct 6'b011001 MULTU: SHALL start a 64-bit unsigned shift-add multiply of src1*src2 into internal HI:LO registers; busy SHALL go 1 on the accepting edge and stay 1 for exactly 32 cycles; HI/LO SHALL hold the full product on the edge busy falls to 0; result and carry SHALL hold their prior values throughout.
REQ-009 funct 6'b010000 MFHI: result = HI; funct 6'b010010 MFLO: result = LO; carry = 0.
REQ-010 Any other funct code: result = 0, carry = 0.
REQ-011 While busy=1, funct/src inputs SHALL be ignored (no operation accepted, result/carry hold); the first operation is accepted on the edge where busy is 0.
REQ-012 MFHI/MFLO issued on the cycle after busy falls SHALL return the completed product.
REQ-013 Multiply SHALL be exact for all operands, including 0 and 0xFFFFFFFF (product 0xFFFFFFFE_00000001).
REQ-014 Arithmetic is unsigned only; no overflow flag, no exceptions.

Reset
REQ-015 rst_n=0 SHALL immediately (asynchronously) force result=0, carry=0, busy=0, HI=0, LO=0, and clear the multiply iteration counter.
REQ-016 Reset asserted mid-multiply SHALL abort it; after release the block SHALL accept a new operation on the first rising edge with rst_n=1.

Verification
REQ-017 src1=0x00000001, src2=0x00000002, funct=001001 -> next edge result=0x00000003, carry=0.
REQ-018 src1=0x00000005, src2=0x00000003, funct=001010 -> result=0x00000002, carry=0; then src1=0x00000003, src2=0x00000005, funct=001010 -> result=0xFFFFFFFE, carry=1.
REQ-019 src1=0xFFFFFFFF, src2=0xFFFFFFFF, funct=001001 -> result=0xFFFFFFFE, carry=1; then src1=0x00000004, src2=0x00000005, funct=001001 -> result=0x00000009, carry=0.
REQ-020 src1=0xFFFFFFFF, src2=0xFFFFFFFF, funct=011001 -> busy=1 for 32 cycles, result unchanged; then MFHI -> 0xFFFFFFFE, MFLO -> 0x00000001.
REQ-021 funct=001010 issued while busy=1 -> ignored, result/carry unchanged; rst_n pulsed low mid-multiply -> result=0, carry=0, busy=0 immediately; MFLO afterwards -> 0x00000000.
REQ-022 funct=111111, any operands -> result=0x00000000, carry=0.

Source files
------------

// File: rtl/alu.sv
// alu: single-cycle unsigned ALU with a 32-cycle shift-add multiplier feeding HI/LO.
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [5:0]  funct,
    output logic [31:0] result,
    output logic        carry,
    output logic        busy
);
    localparam logic [5:0] F_ADDU  = 6'b001001;
    localparam logic [5:0] F_SUBU  = 6'b001010;
    localparam logic [5:0] F_SLTU  = 6'b001011;
    localparam logic [5:0] F_AND   = 6'b001100;
    localparam logic [5:0] F_OR    = 6'b001101;
    localparam logic [5:0] F_XOR   = 6'b001110;
    localparam logic [5:0] F_NOR   = 6'b001111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;

    logic [31:0] result_q, result_d, hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic        carry_q, carry_d, busy_q, busy_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [32:0] sum, diff, step;

    assign sum  = {1'b0, src1} + {1'b0, src2};
    assign diff = {1'b0, src1} - {1'b0, src2};
    // LO starts as the multiplier and fills with product bits as it shifts right
    assign step = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : 33'd0);

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        if (busy_q) begin
            hi_d   = step[32:1];
            lo_d   = {step[0], lo_q[31:1]};
            cnt_d  = cnt_q + 5'd1;
            busy_d = cnt_q != 5'd31;
        end else begin
            carry_d = 1'b0;
            case (funct)
                F_ADDU:  begin result_d = sum[31:0]; carry_d = sum[32]; end
                F_SUBU:  begin result_d = diff[31:0]; carry_d = diff[32]; end
                F_SLTU:  result_d = {31'b0, diff[32]};
                F_AND:   result_d = src1 & src2;
                F_OR:    result_d = src1 | src2;
                F_XOR:   result_d = src1 ^ src2;
                F_NOR:   result_d = ~(src1 | src2);
                F_MFHI:  result_d = hi_q;
                F_MFLO:  result_d = lo_q;
                F_MULTU: begin
                    carry_d = carry_q;
                    busy_d  = 1'b1;
                    cnt_d   = 5'd0;
                    hi_d    = 32'd0;
                    lo_d    = src2;
                    mcand_d = src1;
                end
                default: result_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'd0;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            mcand_q  <= 32'd0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
        end
    end

    assign result = result_q;
    assign carry  = carry_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu; each task checks its own scenario inline.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] src1 = '0, src2 = '0;
    logic [5:0]  funct = '0;
    logic [31:0] result;
    logic        carry, busy;
    int          total = 0, passed = 0;

    alu dut (.clk(clk), .rst_n(rst_n), .src1(src1), .src2(src2), .funct(funct),
             .result(result), .carry(carry), .busy(busy));

    always #5 clk = ~clk;

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
        @(negedge clk);
        src1 = a; src2 = b; funct = f;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({result, carry, busy} !== 34'd0) $display("FAIL reset_state: got %h/%b/%b want 0/0/0", result, carry, busy);
        else passed++;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        run(32'h1, 32'h2, 6'b001001);
        total++;
        if (result !== 32'h3 || carry !== 1'b0) $display("FAIL addu_1_2: got %h/%b want 00000003/0", result, carry);
        else passed++;
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b001001);
        total++;
        if (result !== 32'hFFFFFFFE || carry !== 1'b1) $display("FAIL addu_max: got %h/%b want fffffffe/1", result, carry);
        else passed++;
        run(32'h4, 32'h5, 6'b001001);
        total++;
        if (result !== 32'h9 || carry !== 1'b0) $display("FAIL addu_4_5: got %h/%b want 00000009/0", result, carry);
        else passed++;
    endtask

    task automatic test_sub;
        run(32'h5, 32'h3, 6'b001010);
        total++;
        if (result !== 32'h2 || carry !== 1'b0) $display("FAIL subu_5_3: got %h/%b want 00000002/0", result, carry);
        else passed++;
        run(32'h3, 32'h5, 6'b001010);
        total++;
        if (result !== 32'hFFFFFFFE || carry !== 1'b1) $display("FAIL subu_3_5: got %h/%b want fffffffe/1", result, carry);
        else passed++;
        run(32'h7, 32'h7, 6'b001010);
        total++;
        if (result !== 32'h0 || carry !== 1'b0) $display("FAIL subu_eq: got %h/%b want 00000000/0", result, carry);
        else passed++;
    endtask

    task automatic test_logic;
        logic [5:0]  fs [6] = '{6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b001011, 6'b001011};
        logic [31:0] as [6] = '{32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h3, 32'h5};
        logic [31:0] bs [6] = '{32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00, 32'h5, 32'h3};
        logic [31:0] es [6] = '{32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0, 32'h000F000F, 32'h1, 32'h0};
        for (int i = 0; i < 6; i++) begin
            run(32'hFFFFFFFF, 32'h1, 6'b001001);
            run(as[i], bs[i], fs[i]);
            total++;
            if (result !== es[i] || carry !== 1'b0)
                $display("FAIL logic_%0d: got %h/%b want %h/0", i, result, carry, es[i]);
            else passed++;
        end
    endtask

    task automatic test_illegal;
        run(32'h4, 32'h5, 6'b001001);
        run(32'hDEADBEEF, 32'h12345678, 6'b111111);
        total++;
        if (result !== 32'h0 || carry !== 1'b0) $display("FAIL illegal_3f: got %h/%b want 0/0", result, carry);
        else passed++;
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b001001);
        run(32'h1, 32'h1, 6'b001000);
        total++;
        if (result !== 32'h0 || carry !== 1'b0) $display("FAIL illegal_08: got %h/%b want 0/0", result, carry);
        else passed++;
    endtask

    task automatic mult(input logic [31:0] a, input logic [31:0] b, input logic [63:0] prod, input string name);
        int n = 0;
        bit held = 1'b1;
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 6'b001001);
        src1 = a; src2 = b; funct = 6'b011001;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (result !== 32'hFFFFFFFE || carry !== 1'b1) held = 1'b0;
        end
        total++;
        if (n !== 32) $display("FAIL %s_busy_cycles: got %0d want 32", name, n);
        else passed++;
        total++;
        if (!held) $display("FAIL %s_hold: result/carry changed while busy, want fffffffe/1", name);
        else passed++;
        src1 = 32'h0; src2 = 32'h0; funct = 6'b010000;
        @(negedge clk);
        total++;
        if (result !== prod[63:32] || carry !== 1'b0) $display("FAIL %s_mfhi: got %h/%b want %h/0", name, result, carry, prod[63:32]);
        else passed++;
        run(32'h0, 32'h0, 6'b010010);
        total++;
        if (result !== prod[31:0]) $display("FAIL %s_mflo: got %h want %h", name, result, prod[31:0]);
        else passed++;
    endtask

    task automatic test_multu;
        mult(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, "mul_max");
        mult(32'h0, 32'hFFFFFFFF, 64'h0, "mul_zero");
        mult(32'h3, 32'h5, 64'hF, "mul_3_5");
        mult(32'h00010000, 32'h00010000, 64'h00000001_00000000, "mul_2p16");
    endtask

    task automatic test_busy_ignore_and_reset;
        run(32'h5, 32'h3, 6'b001010);
        src1 = 32'hFFFFFFFF; src2 = 32'hFFFFFFFF; funct = 6'b011001;
        repeat (5) @(negedge clk);
        src1 = 32'h3; src2 = 32'h5; funct = 6'b001010;
        @(negedge clk);
        total++;
        if (result !== 32'h2 || carry !== 1'b0 || busy !== 1'b1)
            $display("FAIL busy_ignore: got %h/%b/%b want 00000002/0/1", result, carry, busy);
        else passed++;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (result !== 32'h0 || carry !== 1'b0 || busy !== 1'b0)
            $display("FAIL async_reset: got %h/%b/%b want 0/0/0", result, carry, busy);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        src1 = 32'h0; src2 = 32'h0; funct = 6'b010010;
        @(negedge clk);
        total++;
        if (result !== 32'h0 || busy !== 1'b0) $display("FAIL mflo_after_reset: got %h/%b want 0/0", result, busy);
        else passed++;
        run(32'h0, 32'h0, 6'b010000);
        total++;
        if (result !== 32'h0) $display("FAIL mfhi_after_reset: got %h want 0", result);
        else passed++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        rst_n = 1'b0;
        src1 = 32'h10; src2 = 32'h20; funct = 6'b001001;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (result !== 32'h30) $display("FAIL first_after_reset: got %h want 00000030", result);
        else passed++;
        src1 = 32'h30; src2 = 32'h1; funct = 6'b001010;
        @(negedge clk);
        total++;
        if (result !== 32'h2F || carry !== 1'b0) $display("FAIL back_to_back: got %h/%b want 0000002f/0", result, carry);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_illegal();
        test_multu();
        test_busy_ignore_and_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
